// File: rtl/mac_tx_arbiter.sv
// rtl/mac_tx_arbiter.sv - frame-level arbiter sharing one MAC TX byte stream among several sources
//
// Purpose:
//   Grants one requesting source per frame and holds that grant until the
//   frame's last byte is accepted by the MAC. The granted source's stream is
//   passed straight through with no added latency. After every frame a
//   programmable idle gap is forced before the next arbitration.
//
// Build option:
//   MAC_TX_ARB_STRICT_PRIO_EN  defined     -> lowest-index requester always wins
//                              not defined -> round-robin starting at rr_ptr
//
// Parameters:
//   NUM_SRC     number of requesters, 1..8
//   IFG_CYCLES  idle cycles forced after each frame's last handshake, 0..255
//
// Ports:
//   logic_clk       in   1          clock
//   logic_rst       in   1          asynchronous active-low reset
//   src_tdata_in    in   NUM_SRC*8  per-source byte, source i on [8i+7:8i]
//   src_tvalid_in   in   NUM_SRC    per-source valid
//   src_tready_out  out  NUM_SRC    per-source ready, only the granted bit can be 1
//   src_tlast_in    in   NUM_SRC    per-source last byte of frame
//   mac_tdata_out   out  8          muxed byte to MAC TX
//   mac_tvalid_out  out  1          muxed valid
//   mac_tready_in   in   1          MAC TX ready
//   mac_tlast_out   out  1          muxed last
//   grant_out       out  NUM_SRC    registered one-hot grant, 0 when no grant
//   busy_out        out  1          1 while a frame or its idle gap is in progress

module mac_tx_arbiter #(
  parameter int NUM_SRC    = 3,
  parameter int IFG_CYCLES = 12
) (
  input  logic                   logic_clk,
  input  logic                   logic_rst,
  input  logic [NUM_SRC*8-1:0]   src_tdata_in,
  input  logic [NUM_SRC-1:0]     src_tvalid_in,
  output logic [NUM_SRC-1:0]     src_tready_out,
  input  logic [NUM_SRC-1:0]     src_tlast_in,
  output logic [7:0]             mac_tdata_out,
  output logic                   mac_tvalid_out,
  input  logic                   mac_tready_in,
  output logic                   mac_tlast_out,
  output logic [NUM_SRC-1:0]     grant_out,
  output logic                   busy_out
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // Value loaded into the gap counter on the last handshake; the GAP state
  // then lasts exactly IFG_CYCLES cycles (counting down to and including 0).
  localparam logic [7:0] GAP_LOAD = (IFG_CYCLES > 0) ? 8'(IFG_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_SRC-1:0] r_grant;
  logic [NUM_SRC-1:0] w_grant_nxt;
  logic [IW-1:0]      r_rr_ptr;
  logic [IW-1:0]      w_rr_ptr_nxt;
  logic [7:0]         r_gap_cnt;
  logic [7:0]         w_gap_cnt_nxt;

  logic               w_any_req;
  logic               w_found;
  logic [IW-1:0]      w_winner;
  int                 w_scan;
  logic               w_last_hs;
  logic [7:0]         w_data_mux;

  assign w_any_req = |src_tvalid_in;

  // Winner selection. The scan visits every source once; the first
  // requesting source encountered wins.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_scan   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
`ifdef MAC_TX_ARB_STRICT_PRIO_EN
      w_scan = k;
`else
      w_scan = int'(r_rr_ptr) + k;
      if (w_scan >= NUM_SRC) begin
        w_scan = w_scan - NUM_SRC;
      end
`endif
      if (!w_found && src_tvalid_in[w_scan[IW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_scan[IW-1:0];
      end
    end
  end

  // The grant register is one-hot and only non-zero in XFER, so masking
  // with it both selects the source and forces all outputs to 0 elsewhere.
  assign w_last_hs = mac_tready_in & (|(src_tvalid_in & src_tlast_in & r_grant));

  always_comb begin
    w_data_mux = 8'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant[i]) begin
        w_data_mux = w_data_mux | src_tdata_in[i*8 +: 8];
      end
    end
  end

  assign mac_tdata_out  = w_data_mux;
  assign mac_tvalid_out = |(src_tvalid_in & r_grant);
  assign mac_tlast_out  = |(src_tlast_in & r_grant);
  assign src_tready_out = r_grant & {NUM_SRC{mac_tready_in}};
  assign grant_out      = r_grant;
  assign busy_out       = (r_state != S_IDLE);

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_gap_cnt_nxt = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = S_XFER;
          w_grant_nxt = NUM_SRC'(1) << w_winner;
`ifdef MAC_TX_ARB_STRICT_PRIO_EN
          w_rr_ptr_nxt = '0;
`else
          if (w_winner == IW'(NUM_SRC - 1)) begin
            w_rr_ptr_nxt = '0;
          end else begin
            w_rr_ptr_nxt = w_winner + 1'b1;
          end
`endif
        end
      end
      S_XFER: begin
        // A source dropping valid mid-frame just stalls; only the last
        // handshake releases the grant.
        if (w_last_hs) begin
          w_grant_nxt = '0;
          if (IFG_CYCLES > 0) begin
            w_state_nxt   = S_GAP;
            w_gap_cnt_nxt = GAP_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == 8'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge logic_clk or negedge logic_rst) begin
    if (!logic_rst) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_gap_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

endmodule
